// File: rtl/chan_mux_rr.sv
// chan_mux_rr: N-channel, W-bit registered multiplexer with valid/ready
// handshakes on every input channel and on the single output.
// A channel is chosen either by a manual select or by a round-robin scan
// that starts at a rotating pointer.
// Optional feature macro: MUX_PARITY_EN adds a registered out_parity output
// (even parity of out_data). Without the macro the port and logic are absent.
//
// Output register state
//   state | meaning
//   EMPTY | no word held, out_valid=0, register loads on any grant
//   FULL  | word held, out_valid=1, reloads only when out_ready=1
module chan_mux_rr #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   localparam int SEL_W   = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      mode,
   input  logic [SEL_W-1:0]          sel,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_chan,
   output logic                      out_valid,
`ifdef MUX_PARITY_EN
   output logic                      out_parity,
`endif
   input  logic                      out_ready
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t           state;
   logic [SEL_W-1:0] ptr;
   logic             load_en;
   logic             man_valid;
   logic             rr_valid;
   logic [SEL_W-1:0] rr_grant;
   logic             grant_valid;
   logic [SEL_W-1:0] grant;
   logic [SEL_W-1:0] ptr_next;
   logic [WIDTH-1:0] grant_data;
   int               rr_idx;

   assign out_valid = (state == FULL);
   assign load_en   = !out_valid || out_ready;

   // Manual grant: sel must name an existing channel that has a word ready.
   always_comb begin
      man_valid = 1'b0;
      if (int'(sel) < CHANNELS) begin
         man_valid = in_valid[sel];
      end
   end

   // Round-robin grant: first valid channel scanning upward from ptr, wrapping.
   always_comb begin
      rr_valid = 1'b0;
      rr_grant = '0;
      rr_idx   = 0;
      for (int k = 0; k < CHANNELS; k++) begin
         rr_idx = int'(ptr) + k;
         if (rr_idx >= CHANNELS) begin
            rr_idx = rr_idx - CHANNELS;
         end
         if (!rr_valid && in_valid[rr_idx[SEL_W-1:0]]) begin
            rr_valid = 1'b1;
            rr_grant = rr_idx[SEL_W-1:0];
         end
      end
   end

   // Pick the active arbitration result and the word it points at.
   always_comb begin
      grant_valid = mode ? rr_valid : man_valid;
      grant       = mode ? rr_grant : sel;
      grant_data  = in_data[grant*WIDTH +: WIDTH];
      ptr_next    = (grant == SEL_W'(CHANNELS - 1)) ? '0 : grant + 1'b1;
   end

   // At most one ready bit, and none while reset is asserted.
   always_comb begin
      in_ready = '0;
      if (rst_n && load_en && grant_valid) begin
         in_ready[grant] = 1'b1;
      end
   end

   // Output register and round-robin pointer; held words stay untouched while stalled.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= EMPTY;
         out_data <= '0;
         out_chan <= '0;
         ptr      <= '0;
      end else if (load_en) begin
         if (grant_valid) begin
            state    <= FULL;
            out_data <= grant_data;
            out_chan <= grant;
            if (mode) begin
               ptr <= ptr_next;
            end
         end else begin
            state <= EMPTY;
         end
      end
   end

`ifdef MUX_PARITY_EN
   // Parity travels with the data word through the same register stage.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_parity <= 1'b0;
      end else if (load_en && grant_valid) begin
         out_parity <= ^grant_data;
      end
   end
`endif

endmodule

// File: tb/tb_chan_mux_rr.sv
// Testbench for chan_mux_rr: directed scenarios plus randomized traffic,
// checked through a scoreboard queue fed by a transaction-level model.
module tb_chan_mux_rr;
   localparam int W  = 8;
   localparam int CH = 4;
   localparam int SW = 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            mode;
   logic [SW-1:0]   sel;
   logic [CH*W-1:0] in_data;
   logic [CH-1:0]   in_valid;
   logic [CH-1:0]   in_ready;
   logic [W-1:0]    out_data;
   logic [SW-1:0]   out_chan;
   logic            out_valid;
   logic            out_ready;
`ifdef MUX_PARITY_EN
   logic            out_parity;
`endif

   always #5 clk = ~clk;

   chan_mux_rr #(.WIDTH(W), .CHANNELS(CH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode),
      .sel       (sel),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_chan  (out_chan),
      .out_valid (out_valid),
`ifdef MUX_PARITY_EN
      .out_parity(out_parity),
`endif
      .out_ready (out_ready)
   );

   typedef struct {
      logic [W-1:0] d;
      int           c;
   } exp_t;

   exp_t         sb[$];
   logic [W-1:0] chdata[CH];
   bit           m_valid;
   int           m_ptr;
   int           tests = 0;
   int           fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference arbitration straight from the rules: -1 means no grant.
   function automatic int ref_grant(bit md, int s, logic [CH-1:0] v, int p);
      if (!md) begin
         if (s < CH && v[s]) return s;
         return -1;
      end
      for (int k = 0; k < CH; k++) begin
         if (v[(p + k) % CH]) return (p + k) % CH;
      end
      return -1;
   endfunction

   // One clock of stimulus: drive, check combinational/state outputs, update model.
   task automatic cycle(input bit rst, input bit md, input int s,
                        input logic [CH-1:0] v, input bit ordy);
      int           g;
      bit           load;
      logic [CH-1:0] exp_rdy;
      @(negedge clk);
      rst_n     = rst;
      mode      = md;
      sel       = SW'(s);
      in_valid  = v;
      out_ready = ordy;
      for (int c = 0; c < CH; c++) in_data[c*W +: W] = chdata[c];
      #1;
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
      g    = ref_grant(md, s, v, m_ptr);
      load = !m_valid || ordy;
      exp_rdy = '0;
      if (rst && load && g >= 0) exp_rdy[g] = 1'b1;
      chk("in_ready", {28'b0, in_ready}, {28'b0, exp_rdy});
      if (!rst) begin
         sb.delete();
         m_valid = 1'b0;
         m_ptr   = 0;
      end else if (load) begin
         m_valid = (g >= 0);
         if (g >= 0) begin
            sb.push_back('{chdata[g], g});
            if (md) m_ptr = (g + 1) % CH;
         end
      end
      @(posedge clk);
      if (rst && load && g >= 0) chdata[g] = W'($urandom);
   endtask

   // Monitor: every completed output handshake must match the oldest expected word.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_output: got data %0h chan %0d expected none", out_data, out_chan);
            end else begin
               e = sb.pop_front();
               chk("out_data", {24'b0, out_data}, {24'b0, e.d});
               chk("out_chan", {30'b0, out_chan}, e.c);
`ifdef MUX_PARITY_EN
               chk("out_parity", {31'b0, out_parity}, {31'b0, ^e.d});
`endif
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; mode = 1'b0; sel = '0; in_valid = '0; in_data = '0; out_ready = 1'b0;
      m_valid = 1'b0; m_ptr = 0;
      for (int c = 0; c < CH; c++) chdata[c] = W'($urandom);

      // Reset with all inputs valid
      cycle(0, 0, 0, 4'hF, 1);
      cycle(0, 1, 0, 4'hF, 1);
      #1;
      chk("rst_data", {24'b0, out_data}, 32'h0);
      chk("rst_chan", {30'b0, out_chan}, 32'h0);
      cycle(1, 0, 0, 4'h0, 1);

      // Manual select
      chdata[2] = 8'hA5;
      cycle(1, 0, 2, 4'b0100, 1);
      #1;
      chk("man_data", {24'b0, out_data}, 32'hA5);
      chk("man_chan", {30'b0, out_chan}, 32'd2);
      chk("man_valid", {31'b0, out_valid}, 32'd1);
      cycle(1, 0, 3, 4'b0100, 1);
      #1;
      chk("man_nogrant", {31'b0, out_valid}, 32'd0);

      // Round-robin, all valid then ch1/ch3 only
      for (int i = 0; i < 5; i++) begin
         cycle(1, 1, 0, 4'hF, 1);
         #1;
         chk("rr_all_seq", {30'b0, out_chan}, i % CH);
      end
      for (int i = 0; i < 4; i++) begin
         cycle(1, 1, 0, 4'b1010, 1);
         #1;
         chk("rr_13_seq", {30'b0, out_chan}, (i % 2 == 0) ? 1 : 3);
      end

      // Backpressure while FULL, then release
      for (int i = 0; i < 3; i++) begin
         cycle(1, 1, 0, 4'hF, 0);
         #1;
         chk("stall_chan", {30'b0, out_chan}, 32'd3);
      end
      cycle(1, 1, 0, 4'hF, 1);
      #1;
      chk("release_chan", {30'b0, out_chan}, 32'd0);

      // Mid-operation reset with a held word
      chdata[1] = 8'h3C;
      cycle(1, 0, 1, 4'b0010, 1);
      cycle(1, 0, 1, 4'b0000, 0);
      #1;
      chk("held_3c", {24'b0, out_data}, 32'h3C);
      cycle(0, 1, 0, 4'hF, 1);
      cycle(1, 1, 0, 4'hF, 1);
      #1;
      chk("post_rst_rr", {30'b0, out_chan}, 32'd0);

`ifdef MUX_PARITY_EN
      chdata[0] = 8'h07;
      cycle(1, 0, 0, 4'b0001, 1);
      #1;
      chk("parity_07", {31'b0, out_parity}, 32'd1);
      chdata[0] = 8'h03;
      cycle(1, 0, 0, 4'b0001, 1);
      #1;
      chk("parity_03", {31'b0, out_parity}, 32'd0);
`endif

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         cycle(($urandom % 64) != 0, $urandom % 2, $urandom % CH,
               CH'($urandom), ($urandom % 10) < 7);
      end

      // Drain and confirm nothing is left outstanding
      for (int i = 0; i < 3; i++) cycle(1, 0, 0, 4'h0, 1);
      chk("sb_empty", sb.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
